message_scheduler: RTL and testbench



---
 rtl/message_scheduler.sv | 167 ++++++++++++++++
 tb/tb_message_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/message_scheduler.sv
// SHA-256 message schedule: loads a 512-bit block and emits W0..W63 one word per STN rising edge.
// W16..W63 are built in place in a 16-word circular buffer through a single shared adder.
module message_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [511:0] block_in,
  input  logic         stn,
  output logic [31:0]  wt_out,
  output logic         wt_valid,
  output logic [5:0]   round_idx,
  output logic         busy,
  output logic         last
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READY,
    CALC1,
    CALC2,
    CALC3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0][31:0]  buf_q, buf_d;
  logic [31:0]        wt_out_q, wt_out_d;
  logic               wt_valid_q, wt_valid_d;
  logic [5:0]         round_idx_q, round_idx_d;
  logic               busy_q, busy_d;
  logic [31:0]        acc_q, acc_d;
  logic               stn_q;

  logic               req;
  logic [5:0]         n_idx;
  logic [3:0]         j_idx;
  logic [31:0]        w_m2, w_m7, w_m15, w_m16;
  logic [31:0]        add_a, add_b, add_sum;
  logic               commit_en;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign req   = stn & ~stn_q;
  assign n_idx = round_idx_q + 6'd1;
  assign j_idx = n_idx[3:0];

  // Buffer indices wrap mod 16; slot j still holds W[n-16] until the commit edge.
  assign w_m2  = buf_q[j_idx - 4'd2];
  assign w_m7  = buf_q[j_idx - 4'd7];
  assign w_m15 = buf_q[j_idx + 4'd1];
  assign w_m16 = buf_q[j_idx];

  always_comb begin
    add_a = 32'd0;
    add_b = 32'd0;
    case (state_q)
      CALC1: begin
        add_a = sig1(w_m2);
        add_b = w_m7;
      end
      CALC2: begin
        add_a = acc_q;
        add_b = sig0(w_m15);
      end
      CALC3: begin
        add_a = acc_q;
        add_b = w_m16;
      end
      default: ;
    endcase
  end

  assign add_sum   = add_a + add_b;
  assign commit_en = (state_q == CALC3) && !load;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slot
      assign buf_d[gi] = load ? block_in[511 - 32*gi -: 32] :
                         (commit_en && (j_idx == 4'(gi))) ? add_sum : buf_q[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    wt_out_d    = wt_out_q;
    wt_valid_d  = wt_valid_q;
    round_idx_d = round_idx_q;
    busy_d      = busy_q;
    acc_d       = acc_q;
    if (load) begin
      state_d     = READY;
      wt_out_d    = block_in[511:480];
      wt_valid_d  = 1'b1;
      round_idx_d = 6'd0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        READY: begin
          if (req) begin
            if (round_idx_q < 6'd15) begin
              round_idx_d = n_idx;
              wt_out_d    = buf_q[j_idx];
            end else if (round_idx_q < LAST_IDX) begin
              busy_d  = 1'b1;
              state_d = CALC1;
            end
          end
        end
        CALC1: begin
          acc_d   = add_sum;
          state_d = CALC2;
        end
        CALC2: begin
          acc_d   = add_sum;
          state_d = CALC3;
        end
        CALC3: begin
          wt_out_d    = add_sum;
          round_idx_d = n_idx;
          busy_d      = 1'b0;
          state_d     = READY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      wt_out_q    <= 32'd0;
      wt_valid_q  <= 1'b0;
      round_idx_q <= 6'd0;
      busy_q      <= 1'b0;
      acc_q       <= 32'd0;
      stn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      wt_out_q    <= wt_out_d;
      wt_valid_q  <= wt_valid_d;
      round_idx_q <= round_idx_d;
      busy_q      <= busy_d;
      acc_q       <= acc_d;
      stn_q       <= stn;
    end
  end

  assign wt_out    = wt_out_q;
  assign wt_valid  = wt_valid_q;
  assign round_idx = round_idx_q;
  assign busy      = busy_q;
  assign last      = wt_valid_q & (round_idx_q == LAST_IDX);

endmodule

// File: tb/tb_message_scheduler.sv
// Bench for message_scheduler: directed "abc" walk, request-edge corner cases and random blocks,
// all compared against a plain-array SHA-256 schedule model.
module tb_message_scheduler;

  logic         clk;
  logic         rst;
  logic         load;
  logic [511:0] block_in;
  logic         stn;
  logic [31:0]  wt_out;
  logic         wt_valid;
  logic [5:0]   round_idx;
  logic         busy;
  logic         last;

  int checks   = 0;
  int failures = 0;
  int cur_t    = 0;
  logic [31:0] exp_w [64];

  message_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .block_in  (block_in),
    .stn       (stn),
    .wt_out    (wt_out),
    .wt_valid  (wt_valid),
    .round_idx (round_idx),
    .busy      (busy),
    .last      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // Textbook schedule over a flat 64-entry array.
  task automatic build_model(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [511:0] blk);
    build_model(blk);
    load = 1'b1;
    block_in = blk;
    step();
    load = 1'b0;
    cur_t = 0;
    check("load_wt", wt_out, exp_w[0]);
    check("load_round", 32'(round_idx), 32'd0);
    check("load_valid", 32'(wt_valid), 32'd1);
    check("load_busy", 32'(busy), 32'd0);
    $display("txn load w0=%h", wt_out);
  endtask

  // One stn pulse, then idle cycles so requests stay spaced as the core would.
  task automatic advance(input int gap);
    stn = 1'b1;
    step();
    stn = 1'b0;
    if (cur_t < 15) begin
      cur_t++;
      check("adv_wt", wt_out, exp_w[cur_t]);
      check("adv_round", 32'(round_idx), 32'(cur_t));
    end else if (cur_t < 63) begin
      check("calc_busy_k", 32'(busy), 32'd1);
      check("calc_hold_k", wt_out, exp_w[cur_t]);
      step();
      step();
      check("calc_busy_k2", 32'(busy), 32'd1);
      check("calc_hold_k2", wt_out, exp_w[cur_t]);
      check("calc_round_k2", 32'(round_idx), 32'(cur_t));
      step();
      cur_t++;
      check("calc_wt", wt_out, exp_w[cur_t]);
      check("calc_round", 32'(round_idx), 32'(cur_t));
      check("calc_busy_done", 32'(busy), 32'd0);
    end else begin
      check("end_wt", wt_out, exp_w[63]);
      check("end_round", 32'(round_idx), 32'd63);
    end
    check("last", 32'(last), (cur_t == 63) ? 32'd1 : 32'd0);
    $display("txn t=%0d wt=%h busy=%0d last=%0d", round_idx, wt_out, busy, last);
    repeat (gap) step();
  endtask

  task automatic rand_block(output logic [511:0] blk);
    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom();
  endtask

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] rblk;
    rst = 1'b1;
    load = 1'b0;
    stn = 1'b0;
    block_in = '0;
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};

    step();
    step();
    rst = 1'b0;
    check("rst_wt", wt_out, 32'd0);
    check("rst_valid", 32'(wt_valid), 32'd0);
    check("rst_round", 32'(round_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last", 32'(last), 32'd0);

    // Requests in IDLE must not move anything.
    stn = 1'b1;
    step();
    stn = 1'b0;
    repeat (4) step();
    check("idle_wt", wt_out, 32'd0);
    check("idle_valid", 32'(wt_valid), 32'd0);
    check("idle_round", 32'(round_idx), 32'd0);

    // Full "abc" walk.
    do_load(abc_blk);
    check("abc_w0", wt_out, 32'h61626380);
    for (int i = 0; i < 15; i++) advance(7);
    check("abc_w15", wt_out, 32'h00000018);
    advance(4);
    check("abc_w16", wt_out, 32'h61626380);
    advance(4);
    check("abc_w17", wt_out, 32'h000F0000);
    while (cur_t < 63) advance(4);
    check("abc_w63", wt_out, 32'h12B1EDEB);
    check("abc_last", 32'(last), 32'd1);
    advance(6);
    check("abc_after64_round", 32'(round_idx), 32'd63);
    check("abc_after64_busy", 32'(busy), 32'd0);

    // Held-high stn yields one advance; a re-raise during CALC2 is dropped.
    rand_block(rblk);
    do_load(rblk);
    for (int i = 0; i < 15; i++) advance(3);
    stn = 1'b1;
    repeat (20) step();
    stn = 1'b0;
    cur_t = 16;
    check("hold_round", 32'(round_idx), 32'd16);
    check("hold_wt", wt_out, exp_w[16]);
    step();
    stn = 1'b1;
    step();
    stn = 1'b0;
    step();
    stn = 1'b1;
    step();
    stn = 1'b0;
    repeat (10) step();
    cur_t = 17;
    check("drop_round", 32'(round_idx), 32'd17);
    check("drop_wt", wt_out, exp_w[17]);
    $display("txn drop t=%0d wt=%h", round_idx, wt_out);

    // Load during CALC2 aborts the calculation; stn high on the load cycle is not a request.
    stn = 1'b1;
    step();
    stn = 1'b0;
    step();
    rand_block(rblk);
    build_model(rblk);
    load = 1'b1;
    block_in = rblk;
    stn = 1'b1;
    step();
    load = 1'b0;
    cur_t = 0;
    check("abort_round", 32'(round_idx), 32'd0);
    check("abort_wt", wt_out, exp_w[0]);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (6) step();
    stn = 1'b0;
    check("abort_noadv_round", 32'(round_idx), 32'd0);
    check("abort_noadv_wt", wt_out, exp_w[0]);
    $display("txn abort t=%0d wt=%h", round_idx, wt_out);
    step();

    // Reset in the middle of a calculation.
    for (int i = 0; i < 15; i++) advance(1);
    stn = 1'b1;
    step();
    stn = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_wt", wt_out, 32'd0);
    check("midrst_round", 32'(round_idx), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(wt_valid), 32'd0);

    // Random blocks with random request spacing.
    for (int b = 0; b < 3; b++) begin
      rand_block(rblk);
      do_load(rblk);
      while (cur_t < 63) advance(int'($urandom_range(1, 8)));
      check("rand_final", wt_out, exp_w[63]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
